// File: rtl/multi_debouncer_pkg.sv
// Shared types and constants for the multi-channel debouncer.
package debounce_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        CHK_HI = 2'd1,
        HIGH   = 2'd2,
        CHK_LO = 2'd3
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_debouncer_if.sv
// Signal bundle for the debouncer: raw inputs toward the block, debounced levels/edges back.
interface multi_debouncer_if #(
    parameter int unsigned CHANNELS = 4
);
    logic [CHANNELS-1:0] in;
    logic [CHANNELS-1:0] out;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;

    modport master (output in, input out, input rise, input fall);
    modport slave  (input in, output out, output rise, output fall);
endinterface

// File: rtl/multi_debouncer_chan.sv
// One debounce channel: 2-flop synchronizer, 4-state stability FSM, optional edge pulses.
// Edge pulses are built only when MULTI_DEBOUNCER_EDGE_EN is defined.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall
);

    localparam int unsigned    CW       = cnt_width(STABLE_CNT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s;
    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   out_q, out_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in};
        s      = sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        if (tick) begin
            case (state_q)
                LOW: begin
                    if (s) begin
                        state_d = CHK_HI;
                        cnt_d   = CW'(1);
                    end
                end
                CHK_HI: begin
                    if (!s) begin
                        state_d = LOW;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = HIGH;
                        out_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HIGH: begin
                    if (!s) begin
                        state_d = CHK_LO;
                        cnt_d   = CW'(1);
                    end
                end
                CHK_LO: begin
                    if (s) begin
                        state_d = HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = LOW;
                        out_d   = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = LOW;
                    cnt_d   = '0;
                    out_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= LOW;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign out = out_q;

`ifdef MULTI_DEBOUNCER_EDGE_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Derived from the next level so the pulse lands in the same cycle out changes.
    always_comb begin
        rise_d = out_d & ~out_q;
        fall_d = ~out_d & out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/multi_debouncer.sv
// Multi-channel debouncer top: shared sample-tick prescaler plus CHANNELS debounce_chan instances.
// Define MULTI_DEBOUNCER_EDGE_EN to enable the rise/fall one-cycle pulses.
module multi_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned STABLE_CNT = 16,
    parameter int unsigned TICK_DIV   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

    logic [15:0] presc_q, presc_d;
    logic        tick;

    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        debounce_chan #(
            .STABLE_CNT (STABLE_CNT)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick),
            .in    (in[i]),
            .out   (out[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed testbench for multi_debouncer (STABLE_CNT=4; TICK_DIV=1 and TICK_DIV=8 instances).
module tb_multi_debouncer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

`ifdef MULTI_DEBOUNCER_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    multi_debouncer_if #(.CHANNELS(4)) bus  ();
    multi_debouncer_if #(.CHANNELS(4)) bus8 ();

    multi_debouncer #(
        .CHANNELS   (4),
        .STABLE_CNT (4),
        .TICK_DIV   (1)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (bus.in),
        .out   (bus.out),
        .rise  (bus.rise),
        .fall  (bus.fall)
    );

    multi_debouncer #(
        .CHANNELS   (4),
        .STABLE_CNT (4),
        .TICK_DIV   (8)
    ) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (bus8.in),
        .out   (bus8.out),
        .rise  (bus8.rise),
        .fall  (bus8.fall)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          vals [7];
        int unsigned lat;
        bit          seen;

        bus.in  = '0;
        bus8.in = '0;
        rst_n   = 1'b0;
        #2;
        check("rst_out",   bus.out,  4'h0);
        check("rst_rise",  bus.rise, 4'h0);
        check("rst_fall",  bus.fall, 4'h0);
        check("rst_out8",  bus8.out, 4'h0);
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();

        // clean press on channel 0: out rises on the 6th edge
        bus.in[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("press_out_e%0d", k),  bus.out,  (k >= 6) ? 4'b0001 : 4'b0000);
            check($sformatf("press_rise_e%0d", k), bus.rise, (k == 6 && EDGE_EN) ? 4'b0001 : 4'b0000);
        end
        step();
        check("press_rise_after", bus.rise, 4'h0);
        check("press_out_hold",   bus.out,  4'b0001);

        // clean release on channel 0
        bus.in[0] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("release_out_e%0d", k),  bus.out,  (k >= 6) ? 4'b0000 : 4'b0001);
            check($sformatf("release_fall_e%0d", k), bus.fall, (k == 6 && EDGE_EN) ? 4'b0001 : 4'b0000);
        end
        step();
        check("release_fall_after", bus.fall, 4'h0);

        // bounce on channel 1: 1,1,0,1,1,1,1 then held high
        vals = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int k = 1; k <= 12; k++) begin
            if (k <= 7) bus.in[1] = vals[k-1];
            step();
            check($sformatf("bounce_out_e%0d", k),  bus.out,  (k >= 9) ? 4'b0010 : 4'b0000);
            check($sformatf("bounce_rise_e%0d", k), bus.rise, (k == 9 && EDGE_EN) ? 4'b0010 : 4'b0000);
        end

        // 3-cycle glitch on channel 2 must be rejected
        bus.in[2] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            if (k == 4) bus.in[2] = 1'b0;
            step();
            check($sformatf("glitch_out_e%0d", k),   bus.out,              4'b0010);
            check($sformatf("glitch_edges_e%0d", k), bus.rise | bus.fall, 4'b0000);
        end

        // reset in the middle of a check, with channel 1 already high
        bus.in[0] = 1'b1;
        repeat (4) step();
        check("midchk_out_before", bus.out, 4'b0010);
        rst_n = 1'b0;
        #1;
        check("midchk_out_in_rst",  bus.out,  4'h0);
        check("midchk_rise_in_rst", bus.rise, 4'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("postrst_out_e%0d", k),  bus.out,  (k >= 6) ? 4'b0011 : 4'b0000);
            check($sformatf("postrst_rise_e%0d", k), bus.rise, (k == 6 && EDGE_EN) ? 4'b0011 : 4'b0000);
        end

        bus.in = '0;
        repeat (10) step();
        check("idle_out", bus.out, 4'h0);

        // prescaled instance: raise channel 3, then measure the falling latency
        bus8.in[3] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (bus8.out[3]) begin
                seen = 1'b1;
                break;
            end
        end
        check("tdiv_rise_seen", 32'(seen), 32'd1);
        repeat (3) step();
        check("tdiv_out_high", bus8.out, 4'b1000);

        bus8.in[3] = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            lat++;
            if (!bus8.out[3]) begin
                seen = 1'b1;
                check("tdiv_fall_pulse", bus8.fall, EDGE_EN ? 4'b1000 : 4'b0000);
                break;
            end
            check($sformatf("tdiv_fall_early_c%0d", lat), bus8.fall, 4'b0000);
        end
        check("tdiv_fall_seen", 32'(seen), 32'd1);
        check("tdiv_lat_window", 32'((lat >= 27) && (lat <= 41)), 32'd1);
        step();
        check("tdiv_fall_after", bus8.fall, 4'h0);
        check("tdiv_out_low",    bus8.out,  4'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent input channels (1..32).
REQ-002 SHALL have parameter STABLE_CNT, default 16: consecutive equal samples required to change state (2..255).
REQ-003 SHALL have parameter TICK_DIV, default 1: clk cycles per sample tick (1..65535); 1 = sample every cycle.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in  input  CHANNELS  raw asynchronous inputs (buttons/switches).
REQ-007 SHALL have port out  output  CHANNELS  debounced level per channel, registered.
REQ-008 SHALL have port rise  output  CHANNELS  one-clk pulse when out goes 0->1 (see REQ-024).
REQ-009 SHALL have port fall  output  CHANNELS  one-clk pulse when out goes 1->0 (see REQ-024).

Function
REQ-010 SHALL pass each in[i] through a 2-flop synchronizer; s[i] is its output, used as the only sampled value.
REQ-011 SHALL contain one shared prescaler counting 0..TICK_DIV-1 and wrapping, with tick=1 in the cycle it equals TICK_DIV-1; TICK_DIV=1 gives tick=1 every cycle.
REQ-012 SHALL run per channel a 4-state FSM: LOW, CHK_HI, HIGH, CHK_LO, plus a counter of width clog2(STABLE_CNT); FSM and counter advance only on tick.
REQ-013 LOW: s=1 -> CHK_HI, cnt=1; s=0 -> stay, out=0.
REQ-014 CHK_HI: s=0 -> LOW, cnt=0; s=1 and cnt=STABLE_CNT-1 -> HIGH, out=1, cnt=0; else cnt+1.
REQ-015 HIGH: s=0 -> CHK_LO, cnt=1; s=1 -> stay, out=1.
REQ-016 CHK_LO: s=1 -> HIGH, cnt=0; s=0 and cnt=STABLE_CNT-1 -> LOW, out=0, cnt=0; else cnt+1.
REQ-017 out SHALL change only on LOW/HIGH entry from a CHK state; a reverting sample SHALL never toggle out.
REQ-018 Counter SHALL never wrap or exceed STABLE_CNT-1.
REQ-019 Latency: out SHALL change exactly 2 + STABLE_CNT ticks-worth after a clean in edge (TICK_DIV=1: 2+STABLE_CNT clk edges).
REQ-020 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each resolve per REQ-013..016.
REQ-021 Glitches shorter than STABLE_CNT ticks SHALL be rejected with no out, rise or fall activity.

Reset
REQ-022 rst_n=0 SHALL immediately force: sync flops 0, prescaler 0, all FSMs LOW, all counters 0, out=0, rise=0, fall=0.
REQ-023 Reset asserted mid-CHK_* SHALL discard progress; after release a held-high input SHALL need the full 2+STABLE_CNT ticks to raise out.

Configuration
REQ-024 Macro MULTI_DEBOUNCER_EDGE_EN defined: rise[i]/fall[i] SHALL pulse high for exactly one clk, in the same cycle out[i] changes value. Undefined: no edge logic generated, rise and fall SHALL be tied 0.

Structure
REQ-025 Package debounce_pkg SHALL hold the FSM state typedef (LOW, CHK_HI, HIGH, CHK_LO) and the synchronizer depth constant (2).
REQ-026 Per-channel logic (synchronizer, FSM, counter, edge detect) SHALL be sub-module debounce_chan, instantiated CHANNELS times by generate; prescaler SHALL stay in the top.

Verification (CHANNELS=4, STABLE_CNT=4, TICK_DIV=1 unless stated)
REQ-027 Clean press: in[0] 0->1 held -> out[0]=1 on 6th clk edge after change, rise[0] single pulse same cycle; other channels stay 0.
REQ-028 Bounce: in[1] sampled 1,1,0,1,1,1,1 -> out[1] rises only after final 4-sample run; no rise pulse earlier.
REQ-029 Glitch: in[2] high 3 cycles then low -> out[2], rise[2], fall[2] stay 0 throughout.
REQ-030 Prescaler TICK_DIV=8: in[3] 1->0 after out[3]=1 -> out[3] falls 2+4*8 cycles later (±7 by tick phase), fall[3] one-clk pulse.
REQ-031 Reset mid-check: in[0] high 4 cycles, pulse rst_n low 1 cycle -> out[0]=0 immediately, then rises 6 cycles after release.
REQ-032 Macro off: repeat REQ-027 -> out identical, rise/fall constantly 0.
